// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STALL_W = 32;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick between icache and dcache requests.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last_grant,
    output owner_t winner_c
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        winner_c = OWN_NONE;
        if (req_i && req_d) begin
            winner_c = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (req_i) begin
            winner_c = OWN_I;
        end else if (req_d) begin
            winner_c = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency main memory between icache and dcache.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [AW-1:0]      i_addr,
    output logic               i_ready,
    output logic [DW-1:0]      i_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [AW-1:0]      d_addr,
    input  logic [DW-1:0]      d_wdata,
    output logic               d_ready,
    output logic [DW-1:0]      d_rdata,
    output logic [AW-1:0]      m_addr,
    output logic [DW-1:0]      m_wd,
    output logic               m_we,
    input  logic [DW-1:0]      m_rd,
    output logic [1:0]         owner,
    output logic [STALL_W-1:0] stall_cnt
);

    state_t           state_q, state_d;
    owner_t           owner_q, last_grant_q, winner_c;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic             grant_c, done_c;
    logic [AW-1:0]    sel_addr_c;
    logic [DW-1:0]    sel_wd_c;
    logic             sel_we_c;

    rr_pick2 u_pick (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (last_grant_q),
        .winner_c   (winner_c)
    );

    assign owner = owner_q;

    // Transaction fields of whichever requester wins this cycle; icache never writes.
    always_comb begin
        sel_addr_c = i_addr;
        sel_wd_c   = '0;
        sel_we_c   = 1'b0;
        if (winner_c == OWN_D) begin
            sel_addr_c = d_addr;
            sel_wd_c   = d_wdata;
            sel_we_c   = d_we;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus grant/complete strobes for the datapath.
    always_comb begin
        state_d = state_q;
        grant_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (winner_c != OWN_NONE) begin
                    grant_c = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    done_c  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched transaction, memory drive, latency counter and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_NONE;
            last_grant_q <= OWN_I;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            m_addr       <= '0;
            m_wd         <= '0;
            m_we         <= 1'b0;
            i_ready      <= 1'b0;
            d_ready      <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            m_we    <= 1'b0;
            if (grant_c) begin
                owner_q <= winner_c;
                we_q    <= sel_we_c;
                m_addr  <= sel_addr_c;
                m_wd    <= sel_wd_c;
                cnt_q   <= CNT_W'(LATENCY - 1);
                // Strobe lands in the final access cycle, which is the first one when LATENCY is 1.
                m_we    <= (LATENCY == 1) && sel_we_c;
            end else if (done_c) begin
                m_addr       <= '0;
                m_wd         <= '0;
                last_grant_q <= owner_q;
                if (owner_q == OWN_I) begin
                    i_ready <= 1'b1;
                    i_rdata <= m_rd;
                end else begin
                    d_ready <= 1'b1;
                    d_rdata <= we_q ? '0 : m_rd;
                end
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q - CNT_W'(1);
                m_we  <= we_q && (cnt_q == CNT_W'(1));
            end else if (state_q == RESP) begin
                owner_q <= OWN_NONE;
            end
        end
    end

    // Saturating count of cycles a request waits behind the other owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (((owner_q == OWN_I && d_req) || (owner_q == OWN_D && i_req))
                     && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a transaction-timing reference model.
module tb_mem_arbiter;

    localparam int unsigned L = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, m_we, i_ready, d_ready;
    logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, m_addr, m_wd, m_rd, stall_cnt;
    logic [1:0]  owner;

    logic        u1_d_req, u1_i_ready, u1_d_ready, u1_m_we;
    logic [31:0] u1_d_addr, u1_i_rdata, u1_d_rdata, u1_m_addr, u1_m_wd, u1_m_rd, u1_stall;
    logic [1:0]  u1_owner;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(L), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_rd(m_rd),
        .owner(owner), .stall_cnt(stall_cnt)
    );

    mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(1'b0), .i_addr(32'h0), .i_ready(u1_i_ready), .i_rdata(u1_i_rdata),
        .d_req(u1_d_req), .d_we(1'b0), .d_addr(u1_d_addr), .d_wdata(32'h0),
        .d_ready(u1_d_ready), .d_rdata(u1_d_rdata),
        .m_addr(u1_m_addr), .m_wd(u1_m_wd), .m_we(u1_m_we), .m_rd(u1_m_rd),
        .owner(u1_owner), .stall_cnt(u1_stall)
    );

    // Main memory: unwritten words read a fixed pattern, writes commit on the strobe edge.
    logic [31:0] mem [256];
    bit          wr_flag [256];

    function automatic logic [31:0] init_val(input int idx);
        return 32'h2002_0001 + 32'(idx);
    endfunction

    always @(posedge clk) begin
        if (m_we) begin
            mem[m_addr[9:2]]     <= m_wd;
            wr_flag[m_addr[9:2]] <= 1'b1;
        end
    end

    assign m_rd    = wr_flag[m_addr[9:2]] ? mem[m_addr[9:2]] : init_val(int'(m_addr[9:2]));
    assign u1_m_rd = u1_m_addr ^ 32'hA5A5_0000;

    int          cyc, vectors, errors;
    bit          busy, t_we, i_done, d_done;
    int          g, w, last_w, exp_stall;
    logic [31:0] t_addr, t_wd;
    logic [31:0] shadow [256];
    int          obs_i_cyc, obs_d_cyc, obs_we_cyc, we_count, obs_u1_cyc;
    logic [31:0] obs_we_addr, obs_we_wd, obs_i_rdata, obs_d_rdata, obs_u1_rdata;
    int          order_q[$];
    int          u1_own[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: a grant in idle cycle g owns cycles g+1..g+L+1, strobes at g+L, responds at g+L+1.
    task automatic model_check();
        int  rc, own, nw;
        bit  just_resp, in_acc;
        just_resp = 1'b0;
        if (!reset) begin
            busy = 1'b0; last_w = 1; exp_stall = 0;
        end
        rc     = g + int'(L) + 1;
        own    = (busy && cyc > g && cyc <= rc) ? w : 0;
        in_acc = busy && cyc > g && cyc < rc;
        chk("owner",   32'(owner),   32'(own));
        chk("i_ready", 32'(i_ready), 32'(busy && w == 1 && cyc == rc));
        chk("d_ready", 32'(d_ready), 32'(busy && w == 2 && cyc == rc));
        chk("m_we",    32'(m_we),    32'(busy && t_we && cyc == g + int'(L)));
        chk("m_addr",  m_addr, in_acc ? t_addr : 32'h0);
        if (!in_acc) chk("m_wd", m_wd, 32'h0);
        else if (w == 2) chk("m_wd", m_wd, t_wd);
        chk("stall_cnt", stall_cnt, 32'(exp_stall));

        if (i_ready) begin obs_i_cyc = cyc; obs_i_rdata = i_rdata; order_q.push_back(1); end
        if (d_ready) begin obs_d_cyc = cyc; obs_d_rdata = d_rdata; order_q.push_back(2); end
        if (m_we) begin we_count++; obs_we_cyc = cyc; obs_we_addr = m_addr; obs_we_wd = m_wd; end
        if (u1_d_ready) begin obs_u1_cyc = cyc; obs_u1_rdata = u1_d_rdata; end
        u1_own.push_back(int'(u1_owner));

        i_done = 1'b0; d_done = 1'b0;
        if (busy && cyc == rc) begin
            if (w == 1) begin
                chk("i_rdata", i_rdata, shadow[t_addr[9:2]]);
                i_done = 1'b1;
            end else begin
                chk("d_rdata", d_rdata, t_we ? 32'h0 : shadow[t_addr[9:2]]);
                if (t_we) shadow[t_addr[9:2]] = t_wd;
                d_done = 1'b1;
            end
            last_w = w; busy = 1'b0; just_resp = 1'b1;
        end
        if ((own == 1 && d_req) || (own == 2 && i_req)) exp_stall++;
        if (reset && !busy && !just_resp) begin
            nw = 0;
            if (i_req && d_req) nw = (last_w == 1) ? 2 : 1;
            else if (i_req)     nw = 1;
            else if (d_req)     nw = 2;
            if (nw != 0) begin
                busy = 1'b1; g = cyc; w = nw;
                t_addr = (nw == 1) ? i_addr : d_addr;
                t_we   = (nw == 2) && d_we;
                t_wd   = d_wdata;
            end
        end
    endtask

    // One clock: check at the falling edge, then release finished requests after the next rise.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        cyc++;
        if (i_done) i_req = 1'b0;
        if (d_done) d_req = 1'b0;
    endtask

    initial begin
        int t0, base, n;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        cyc = 0; vectors = 0; errors = 0; busy = 1'b0; last_w = 1; exp_stall = 0;
        g = 0; w = 0; t_we = 1'b0; t_addr = '0; t_wd = '0; we_count = 0;
        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        u1_d_req = 0; u1_d_addr = 0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Lone icache read.
        t0 = cyc; base = we_count; obs_i_cyc = -1;
        i_req = 1; i_addr = 32'h10;
        repeat (7) tick();
        chk("t1_ready_cycle", 32'(obs_i_cyc), 32'(t0 + 5));
        chk("t1_rdata", obs_i_rdata, 32'h2002_0005);
        chk("t1_no_we", 32'(we_count), 32'(base));

        // Lone dcache write.
        t0 = cyc; base = we_count; obs_d_cyc = -1; obs_we_cyc = -1;
        d_req = 1; d_we = 1; d_addr = 32'h54; d_wdata = 32'h7;
        repeat (7) tick();
        d_we = 0;
        chk("t2_we_count", 32'(we_count), 32'(base + 1));
        chk("t2_we_cycle", 32'(obs_we_cyc), 32'(t0 + 4));
        chk("t2_we_addr", obs_we_addr, 32'h54);
        chk("t2_we_data", obs_we_wd, 32'h7);
        chk("t2_ready_cycle", 32'(obs_d_cyc), 32'(t0 + 5));
        chk("t2_rdata", obs_d_rdata, 32'h0);

        // Simultaneous requests straight after reset: dcache first.
        reset = 1'b0; tick(); reset = 1'b1; tick();
        t0 = cyc; obs_i_cyc = -1; obs_d_cyc = -1;
        i_req = 1; i_addr = 32'h54; d_req = 1; d_addr = 32'h20;
        repeat (13) tick();
        chk("t3_d_ready_cycle", 32'(obs_d_cyc), 32'(t0 + 5));
        chk("t3_i_ready_cycle", 32'(obs_i_cyc), 32'(t0 + 11));
        chk("t3_i_rdata", obs_i_rdata, 32'h7);
        chk("t3_stall", stall_cnt, 32'd5);

        // Continuous contention alternates grants.
        order_q.delete();
        i_req = 1; i_addr = 32'h30; d_req = 1; d_addr = 32'h34; d_we = 0;
        n = 0;
        while (n < 60 && !(order_q.size() >= 4 && !i_req && !d_req)) begin
            tick();
            n++;
            if (order_q.size() < 4) begin
                if (!i_req && !i_done) i_req = 1;
                if (!d_req && !d_done) d_req = 1;
            end
        end
        chk("t4_drain", 32'(i_req | d_req), 32'h0);
        chk("t4_g0", 32'(order_q.size() > 0 ? order_q[0] : 0), 32'd2);
        chk("t4_g1", 32'(order_q.size() > 1 ? order_q[1] : 0), 32'd1);
        chk("t4_g2", 32'(order_q.size() > 2 ? order_q[2] : 0), 32'd2);
        chk("t4_g3", 32'(order_q.size() > 3 ? order_q[3] : 0), 32'd1);

        // LATENCY=1 read on the second instance.
        t0 = cyc; obs_u1_cyc = -1; u1_own.delete();
        u1_d_req = 1; u1_d_addr = 32'h40;
        repeat (3) tick();
        u1_d_req = 0;
        tick();
        chk("t5_ready_cycle", 32'(obs_u1_cyc), 32'(t0 + 2));
        chk("t5_rdata", obs_u1_rdata, 32'hA5A5_0040);
        for (int k = 0; k < 4; k++) begin
            chk("t5_owner", 32'(u1_own.size() > k ? u1_own[k] : -1), (k == 1 || k == 2) ? 32'd2 : 32'd0);
        end

        // Reset during a dcache write aborts it before the strobe.
        t0 = cyc; base = we_count;
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
        repeat (2) tick();
        reset = 1'b0; d_req = 0; d_we = 0;
        #1;
        chk("t6_owner", 32'(owner), 32'h0);
        chk("t6_m_addr", m_addr, 32'h0);
        chk("t6_m_wd", m_wd, 32'h0);
        chk("t6_m_we", 32'(m_we), 32'h0);
        chk("t6_i_rdata", i_rdata, 32'h0);
        chk("t6_stall", stall_cnt, 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("t6_no_we", 32'(we_count), 32'(base));
        t0 = cyc; obs_d_cyc = -1;
        d_req = 1; d_addr = 32'h80;
        repeat (7) tick();
        chk("t6_restart_cycle", 32'(obs_d_cyc), 32'(t0 + 5));
        chk("t6_restart_rdata", obs_d_rdata, 32'h2002_0021);

        // Randomized traffic from both requesters.
        for (int k = 0; k < 800; k++) begin
            if (!i_req && !i_done && $urandom_range(0, 2) == 0) begin
                i_req  = 1;
                i_addr = {22'b0, 8'($urandom), 2'b00};
            end
            if (!d_req && !d_done && $urandom_range(0, 2) == 0) begin
                d_req   = 1;
                d_we    = 1'($urandom);
                d_addr  = {22'b0, 8'($urandom), 2'b00};
                d_wdata = $urandom;
            end
            tick();
        end
        n = 0;
        while (n < 40 && (i_req || d_req)) begin
            tick();
            n++;
        end
        chk("rand_drain", 32'(i_req | d_req), 32'h0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
